// File: rtl/sbox_share_sched.sv
// One AES s-box shared by a 16-byte state port and a 4-byte key-word port, one byte per cycle.
// Done follows grant by 16 (state) or 4 (key) edges; both ports round-robin, and a waiting request holds its level.

module s_box (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Entry for input x sits at bits [8*(255-x) +: 8]; ~x gives 255-x.
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = TABLE[{~i_byte, 3'b000} +: 8];
endmodule

module sbox_share_sched #(
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         kw_req,
    input  logic [31:0]  kw_data,
    output logic         kw_done,
    output logic [31:0]  kw_result,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW, DONE} state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [15:0][7:0]   r_work;
    logic               r_last_kw;

    logic               w_st_elig;
    logic               w_kw_elig;
    logic               w_grant_kw;
    logic               w_grant_st;
    logic [3:0]         w_idx;
    logic [7:0]         w_sbox_in;
    logic [7:0]         w_sbox_out;

    assign w_st_elig  = st_req & ~st_done;
    assign w_kw_elig  = kw_req & ~kw_done;
    assign w_grant_kw = w_kw_elig & (~w_st_elig | ~r_last_kw);
    assign w_grant_st = w_st_elig & ~w_grant_kw;

    // Byte 0 is the most significant byte, so packed index counts down from the top.
    assign w_idx     = (r_state == RUN_KW) ? {2'b00, 2'd3 - r_cnt[1:0]} : 4'd15 - r_cnt;
    assign w_sbox_in = r_work[w_idx];

    s_box u_sbox (
        .i_byte (w_sbox_in),
        .o_byte (w_sbox_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_work    <= '0;
            r_last_kw <= ~KEY_FIRST;
            st_done   <= 1'b0;
            kw_done   <= 1'b0;
            st_result <= '0;
            kw_result <= '0;
            busy      <= 1'b0;
        end else begin
            st_done <= 1'b0;
            kw_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_kw) begin
                        r_work    <= {96'd0, kw_data};
                        r_cnt     <= 4'd0;
                        r_last_kw <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= RUN_KW;
                    end else if (w_grant_st) begin
                        r_work    <= st_data;
                        r_cnt     <= 4'd0;
                        r_last_kw <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= RUN_ST;
                    end
                end
                RUN_ST: begin
                    r_work[w_idx] <= w_sbox_out;
                    if (r_cnt == 4'd15) begin
                        st_result <= {r_work[15:1], w_sbox_out};
                        st_done   <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RUN_KW: begin
                    r_work[w_idx] <= w_sbox_out;
                    if (r_cnt == 4'd3) begin
                        kw_result <= {r_work[3:1], w_sbox_out};
                        kw_done   <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_share_sched.sv
// Bench for sbox_share_sched: transaction-level model with an arithmetic AES s-box,
// checked every cycle, plus directed latency/order/reset cases and a random phase.

module tb_sbox_share_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic         st_req;
    logic [127:0] st_data;
    logic         st_done;
    logic [127:0] st_result;
    logic         kw_req;
    logic [31:0]  kw_data;
    logic         kw_done;
    logic [31:0]  kw_result;
    logic         busy;

    always #5 clk = ~clk;

    sbox_share_sched #(.KEY_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_req    (st_req),
        .st_data   (st_data),
        .st_done   (st_done),
        .st_result (st_result),
        .kw_req    (kw_req),
        .kw_data   (kw_data),
        .kw_done   (kw_done),
        .kw_result (kw_result),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // AES s-box built from GF(2^8) inversion plus the affine map.
    logic [7:0] m_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'd0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'd0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'd1) inv = 8'(y);
            m_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_state(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = m_sbox[x[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = m_sbox[x[8*k +: 8]];
        return r;
    endfunction

    // Model: m_t counts edges since the grant (-1 when idle); the result appears
    // m_len edges after the grant and the block is free one edge later.
    int           m_t       = -1;
    int           m_len     = 16;
    bit           m_kw      = 1'b0;
    bit           m_last_kw = 1'b0;
    logic [127:0] m_cap     = '0;
    logic [127:0] m_st_res  = '0;
    logic [31:0]  m_kw_res  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t       = -1;
            m_st_res  = '0;
            m_kw_res  = '0;
            m_last_kw = 1'b0;
        end else if (m_t < 0) begin
            if (st_req || kw_req) begin
                m_kw      = kw_req && (!st_req || !m_last_kw);
                m_last_kw = m_kw;
                m_len     = m_kw ? 4 : 16;
                m_cap     = m_kw ? {96'd0, kw_data} : st_data;
                m_t       = 0;
            end
        end else begin
            m_t++;
            if (m_t == m_len) begin
                if (m_kw) m_kw_res = sub_word(m_cap[31:0]);
                else      m_st_res = sub_state(m_cap);
            end else if (m_t == m_len + 1) begin
                m_t = -1;
            end
        end
    end

    bit cmp_on = 1'b1;
    always begin
        logic [2:0] exp_ctl;
        @(posedge clk);
        #1;
        if (cmp_on) begin
            exp_ctl = {m_t >= 0, m_t >= 0 && m_t == m_len && !m_kw, m_t >= 0 && m_t == m_len && m_kw};
            check("ctl busy/st_done/kw_done", 192'({busy, st_done, kw_done}), 192'(exp_ctl));
            check("st_result", 192'(st_result), 192'(m_st_res));
            check("kw_result", 192'(kw_result), 192'(m_kw_res));
        end
    end

    task automatic wait_done(input bit key, output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (key ? kw_done : st_done) return;
        end
        check(key ? "kw_done timeout" : "st_done timeout", 192'(0), 192'(1));
        lat = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, limit 2000000 time units");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           t;
        bit           order_q[$];
        int           when_q[$];
        logic [127:0] d0;
        logic [127:0] dv;
        logic [31:0]  w0;

        rst = 1'b1; st_req = 1'b0; kw_req = 1'b0; st_data = '0; kw_data = '0;
        build_sbox();
        check("model sbox[00]", 192'(m_sbox[8'h00]), 192'(8'h63));
        check("model sbox[53]", 192'(m_sbox[8'h53]), 192'(8'hed));

        repeat (3) @(negedge clk);
        check("reset outputs", 192'({busy, st_done, kw_done, st_result, kw_result}), 192'(0));

        // Known-answer state operation, requested on the edge right after reset release.
        rst = 1'b0; st_req = 1'b1; st_data = 128'h00112233445566778899aabbccddeeff;
        wait_done(1'b0, lat);
        check("st latency", 192'(lat), 192'(17));
        check("st known answer", 192'(st_result), 192'(128'h638293c31bfc33f5c4eeacea4bc12816));
        st_req = 1'b0;
        @(negedge clk);

        kw_req = 1'b1; kw_data = 32'hcf4f3c09;
        wait_done(1'b1, lat);
        check("kw latency", 192'(lat), 192'(5));
        check("kw known answer", 192'(kw_result), 192'(32'h8a84eb01));
        kw_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: key, state, key.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; st_req = 1'b1; kw_req = 1'b1;
        st_data = {$urandom, $urandom, $urandom, $urandom}; kw_data = $urandom;
        t = 0;
        for (int i = 0; i < 100 && order_q.size() < 3; i++) begin
            @(negedge clk);
            t++;
            if (st_done || kw_done) begin
                order_q.push_back(kw_done);
                when_q.push_back(t);
            end
        end
        st_req = 1'b0; kw_req = 1'b0;
        check("rr done count", 192'(order_q.size()), 192'(3));
        if (order_q.size() == 3) begin
            check("rr first is key", 192'(order_q[0]), 192'(1));
            check("rr second is state", 192'(order_q[1]), 192'(0));
            check("rr third is key", 192'(order_q[2]), 192'(1));
            check("rr first done cycle", 192'(when_q[0]), 192'(5));
            check("rr second done cycle", 192'(when_q[1]), 192'(23));
            check("rr third done cycle", 192'(when_q[2]), 192'(29));
        end
        @(negedge clk);

        // Reset while byte 7 is in flight; request held throughout.
        d0 = {$urandom, $urandom, $urandom, $urandom};
        st_req = 1'b1; st_data = d0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort outputs zero", 192'({busy, st_done, kw_done, st_result, kw_result}), 192'(0));
        @(negedge clk);
        rst = 1'b0;
        wait_done(1'b0, lat);
        check("restart latency", 192'(lat), 192'(17));
        check("restart result", 192'(st_result), 192'(sub_state(d0)));
        st_req = 1'b0;
        @(negedge clk);

        // Data changes after the grant are ignored; kw_result holds.
        w0 = $urandom;
        kw_req = 1'b1; kw_data = w0;
        wait_done(1'b1, lat);
        kw_req = 1'b0;
        @(negedge clk);
        d0 = {$urandom, $urandom, $urandom, $urandom};
        st_req = 1'b1; st_data = d0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (st_done) break;
            if (lat % 6 == 3) begin
                st_data = {$urandom, $urandom, $urandom, $urandom};
                kw_data = $urandom;
            end
        end
        check("mid-op data change latency", 192'(lat), 192'(17));
        check("captured state only", 192'(st_result), 192'(sub_state(d0)));
        check("kw_result held", 192'(kw_result), 192'(sub_word(w0)));
        st_req = 1'b0;
        @(negedge clk);

        // All 256 byte values through 16 state operations.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) dv[127 - 8*k -: 8] = 8'(16*i + k);
            st_req = 1'b1; st_data = dv;
            wait_done(1'b0, lat);
            for (int k = 0; k < 16; k++) d0[127 - 8*k -: 8] = m_sbox[16*i + k];
            check($sformatf("sweep %0d", i), 192'(st_result), 192'(d0));
            st_req = 1'b0;
            @(negedge clk);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (st_req && st_done) st_req = 1'($urandom_range(0, 1));
            else if (!st_req) st_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) st_data = {$urandom, $urandom, $urandom, $urandom};
            if (kw_req && kw_done) kw_req = 1'($urandom_range(0, 1));
            else if (!kw_req) kw_req = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) kw_data = $urandom;
        end
        rst = 1'b0; st_req = 1'b0; kw_req = 1'b0;
        repeat (25) @(negedge clk);
        cmp_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sbox_share_sched.md
SBOX_SHARE_SCHED -- requirements
Module: sbox_share_sched

Interface
REQ-001 SHALL have parameter KEY_FIRST, default 1: requester granted first after reset when both request in the same cycle (1 = key port, 0 = state port).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port st_req  input  1  state-port request, level; held until st_done.
REQ-005 SHALL have port st_data  input  128  state to substitute; byte 0 = [127:120].
REQ-006 SHALL have port st_done  output  1  one-cycle pulse, st_result valid.
REQ-007 SHALL have port st_result  output  128  SubBytes(st_data), same byte order.
REQ-008 SHALL have port kw_req  input  1  key-schedule SubWord request, level; held until kw_done.
REQ-009 SHALL have port kw_data  input  32  word to substitute; byte 0 = [31:24].
REQ-010 SHALL have port kw_done  output  1  one-cycle pulse, kw_result valid.
REQ-011 SHALL have port kw_result  output  32  SubWord(kw_data).
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL instantiate exactly one s_box; all substitutions are time-multiplexed through it, one byte per cycle.
REQ-014 SHALL implement FSM states IDLE, RUN_ST, RUN_KW, DONE.
REQ-015 IDLE: at a clock edge with an eligible request, SHALL grant, capture that port's data into an internal work register, clear byte counter to 0, and enter RUN_ST or RUN_KW.
REQ-016 Eligible = req high and the same port's done output low in that cycle.
REQ-017 Both requests eligible in IDLE: SHALL grant the port not granted last (round-robin). After reset, the last-grant pointer SHALL make the KEY_FIRST port win.
REQ-018 Single requester eligible: SHALL grant it regardless of pointer.
REQ-019 RUN_ST: each edge SHALL write s_box(work byte[cnt]) to result byte[cnt] and increment cnt. cnt runs 0..15 in byte order 0 first, then the FSM enters DONE.
REQ-020 RUN_KW: same as RUN_ST with cnt 0..3, then enter DONE.
REQ-021 cnt SHALL be 4 bits and SHALL reset to 0 on grant; no wrap is used beyond 15.
REQ-022 DONE: SHALL assert the served port's done for exactly one cycle, then return to IDLE; no grant occurs in DONE.
REQ-023 st_result/kw_result SHALL be output registers updated only on the DONE transition of their own port and held otherwise.
REQ-024 Latency: grant edge N gives done high in the cycle after edge N+16 (state) or N+4 (key). Minimum grant-to-grant spacing SHALL be 18 cycles (state) or 6 cycles (key).
REQ-025 Req or data changes after the grant SHALL NOT affect the operation in progress.
REQ-026 A request arriving during RUN/DONE SHALL wait; it is not lost if held high.
REQ-027 A requester keeping req high after its done SHALL be re-served, starting at the first IDLE cycle after done.

Reset
REQ-028 While rst=1, regardless of clk, the block SHALL force: FSM IDLE, cnt 0, st_done=0, kw_done=0, busy=0, st_result=0, kw_result=0, work register 0, pointer to the KEY_FIRST setting.
REQ-029 Reset during RUN SHALL abort the operation; no done pulse SHALL follow for the aborted request.
REQ-030 The first grant SHALL occur at the first rising edge after rst falls with a request present.

Verification
REQ-031 Drive st_req=1, st_data=00112233445566778899aabbccddeeff. The bench SHALL see st_done 16 cycles after grant and st_result=638293c31bfc33f5c4eeacea4bc12816.
REQ-032 Drive kw_req=1, kw_data=cf4f3c09. The bench SHALL see kw_done 4 cycles after grant and kw_result=8a84eb01.
REQ-033 Assert st_req and kw_req on the same edge after reset with KEY_FIRST=1 and both held. Required order: key served first, then state, then key; grants alternate.
REQ-034 Pulse rst at state-operation byte 7. The bench SHALL see all outputs 0 immediately and no st_done. With st_req held, the operation SHALL restart from byte 0 after reset release.
REQ-035 Change st_data mid-operation. st_result SHALL reflect only the captured value, and kw_result SHALL stay unchanged throughout.
REQ-036 Drive all 256 byte values via 16 state requests. Every result byte SHALL match the s_box table, and busy SHALL be low only in IDLE.
